// File: rtl/tetris_pkg.sv
// Shared Tetris definitions: piece encoding, bag constants and bag-mask helpers.
package tetris_pkg;

    typedef enum logic [2:0] {
        PIECE_I    = 3'd0,
        PIECE_O    = 3'd1,
        PIECE_T    = 3'd2,
        PIECE_S    = 3'd3,
        PIECE_Z    = 3'd4,
        PIECE_J    = 3'd5,
        PIECE_L    = 3'd6,
        PIECE_NONE = 3'd7
    } piece_type_t;

    localparam int             PIECE_W  = 3;
    localparam int             BAG_SIZE = 7;
    localparam logic [6:0]     BAG_FULL = 7'h7F;

    // True when p is a real piece that has not yet been drawn from the bag.
    function automatic logic bag_has(input logic [6:0] mask, input logic [2:0] p);
        return (p != 3'd7) && ((mask & (7'd1 << p)) != 7'd0);
    endfunction

    // Remove p from the bag; an emptied bag refills in the same step.
    function automatic logic [6:0] bag_take(input logic [6:0] mask, input logic [2:0] p);
        logic [6:0] m;
        m = mask & ~(7'd1 << p);
        return (m == 7'd0) ? BAG_FULL : m;
    endfunction

endpackage

// File: rtl/piece_bag_gen_if.sv
// Pop handshake between the piece generator (slave) and the game engine (master).
interface piece_bag_gen_if;
    import tetris_pkg::*;

    logic        piece_req;
    logic        piece_valid;
    piece_type_t piece_out;

    modport master (output piece_req, input piece_valid, input piece_out);
    modport slave  (input piece_req, output piece_valid, output piece_out);
endinterface

// File: rtl/piece_bag_gen_queue.sv
// piece_queue: shift-toward-head FIFO of piece codes. Unused slots always hold 3'd7,
// so the flat slot output can feed the preview display directly.
module piece_queue
    import tetris_pkg::*;
#(
    parameter int DEPTH = 6
) (
    input  logic                     clk,
    input  logic                     rst_l,
    input  logic                     clear,
    input  logic                     push,
    input  logic [PIECE_W-1:0]       push_data,
    input  logic                     pop,
    output logic [3:0]               count,
    output logic                     full,
    output logic                     empty,
    output logic [PIECE_W*DEPTH-1:0] slots
);

    localparam logic [3:0] DEPTH_C = 4'(DEPTH);

    logic [PIECE_W-1:0] slot_q [DEPTH];
    logic [PIECE_W-1:0] slot_d [DEPTH];
    logic [3:0]         count_q;
    logic [3:0]         count_d;
    logic               pop_s;
    logic               push_s;
    logic [3:0]         wr_idx_s;

    // Next-state: clear, then shift on pop, then write push data at the tail.
    always_comb begin
        slot_d   = slot_q;
        count_d  = count_q;
        pop_s    = pop && (count_q != 4'd0);
        push_s   = push && ((count_q < DEPTH_C) || pop_s);
        wr_idx_s = pop_s ? (count_q - 4'd1) : count_q;
        if (clear) begin
            for (int i = 0; i < DEPTH; i++) slot_d[i] = 3'd7;
            count_d = 4'd0;
        end else begin
            if (pop_s) begin
                for (int i = 0; i < DEPTH - 1; i++) slot_d[i] = slot_q[i+1];
                slot_d[DEPTH-1] = 3'd7;
            end else begin
                slot_d = slot_q;
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (push_s && (4'(i) == wr_idx_s)) slot_d[i] = push_data;
                else slot_d[i] = slot_d[i];
            end
            if (push_s && !pop_s)      count_d = count_q + 4'd1;
            else if (pop_s && !push_s) count_d = count_q - 4'd1;
            else                       count_d = count_q;
        end
    end

    // Queue storage and occupancy registers.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            for (int i = 0; i < DEPTH; i++) slot_q[i] <= 3'd7;
            count_q <= 4'd0;
        end else begin
            slot_q  <= slot_d;
            count_q <= count_d;
        end
    end

    // Flatten slots for the display; slot 0 occupies the low bits.
    always_comb begin
        slots = '0;
        for (int i = 0; i < DEPTH; i++) slots[i*PIECE_W +: PIECE_W] = slot_q[i];
    end

    assign count = count_q;
    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == 4'd0);

endmodule

// File: rtl/piece_bag_gen.sv
// piece_bag_gen: turns the LFSR bit stream into 7-bag Tetris pieces and buffers them
// in a preview queue. Optional reject statistics: define PIECE_BAG_STATS_EN.
module piece_bag_gen
    import tetris_pkg::*;
#(
    parameter int PREVIEW_DEPTH = 6
) (
    input  logic                             clk,
    input  logic                             rst_l,
    input  logic                             rand_bit,
    input  logic                             new_game,
    piece_bag_gen_if.slave                   pop_if,
    output logic [PIECE_W*PREVIEW_DEPTH-1:0] preview,
    output logic [3:0]                       preview_count,
    output logic [BAG_SIZE-1:0]              bag_remaining,
    output logic [15:0]                      reject_count
);

    logic [1:0]          bit_cnt_q, bit_cnt_d;
    logic [1:0]          shreg_q, shreg_d;
    logic [BAG_SIZE-1:0] mask_q, mask_d;
    logic [2:0]          candidate_s;
    logic                eval_s;
    logic                pop_s;
    logic                accept_s;
    logic                q_full_s;
    logic                q_empty_s;

    // Bit gathering, acceptance decision and bag-mask update.
    always_comb begin
        shreg_d     = {shreg_q[0], rand_bit};
        candidate_s = {shreg_q, rand_bit};
        eval_s      = (bit_cnt_q == 2'd2) && !new_game;
        pop_s       = pop_if.piece_req && !q_empty_s && !new_game;
        accept_s    = eval_s && bag_has(mask_q, candidate_s) && (!q_full_s || pop_s);
        if (new_game)                bit_cnt_d = 2'd0;
        else if (bit_cnt_q == 2'd2)  bit_cnt_d = 2'd0;
        else                         bit_cnt_d = bit_cnt_q + 2'd1;
        if (new_game)      mask_d = BAG_FULL;
        else if (accept_s) mask_d = bag_take(mask_q, candidate_s);
        else               mask_d = mask_q;
    end

    // Gathering and bag state registers.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            bit_cnt_q <= 2'd0;
            shreg_q   <= 2'd0;
            mask_q    <= BAG_FULL;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            mask_q    <= mask_d;
        end
    end

    piece_queue #(.DEPTH(PREVIEW_DEPTH)) u_queue (
        .clk       (clk),
        .rst_l     (rst_l),
        .clear     (new_game),
        .push      (accept_s),
        .push_data (candidate_s),
        .pop       (pop_s),
        .count     (preview_count),
        .full      (q_full_s),
        .empty     (q_empty_s),
        .slots     (preview)
    );

    assign pop_if.piece_valid = !q_empty_s;
    assign pop_if.piece_out   = piece_type_t'(preview[PIECE_W-1:0]);
    assign bag_remaining      = mask_q;

`ifdef PIECE_BAG_STATS_EN
    logic [15:0] rej_q, rej_d;
    logic        reject_s;

    // Saturating count of evaluation edges whose candidate was discarded.
    always_comb begin
        reject_s = eval_s && !accept_s;
        if (reject_s && (rej_q != 16'hFFFF)) rej_d = rej_q + 16'd1;
        else                                 rej_d = rej_q;
    end

    // Reject counter register; only rst_l clears it.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) rej_q <= 16'd0;
        else        rej_q <= rej_d;
    end

    assign reject_count = rej_q;
`else
    assign reject_count = 16'h0;
`endif

endmodule

// File: tb/tb_piece_bag_gen.sv
// Directed self-checking bench for piece_bag_gen (PREVIEW_DEPTH = 6).
module tb_piece_bag_gen;
    import tetris_pkg::*;

    logic        clk = 1'b0;
    logic        rst_l = 1'b0;
    logic        rand_bit = 1'b0;
    logic        new_game = 1'b0;
    logic [17:0] preview;
    logic [3:0]  preview_count;
    logic [6:0]  bag_remaining;
    logic [15:0] reject_count;
    int          n_cmp = 0;
    int          n_bad = 0;

    piece_bag_gen_if pop_if ();

    piece_bag_gen #(.PREVIEW_DEPTH(6)) dut (
        .clk           (clk),
        .rst_l         (rst_l),
        .rand_bit      (rand_bit),
        .new_game      (new_game),
        .pop_if        (pop_if.slave),
        .preview       (preview),
        .preview_count (preview_count),
        .bag_remaining (bag_remaining),
        .reject_count  (reject_count)
    );

    always #5 clk = ~clk;

    function automatic logic [17:0] prev6(input logic [2:0] a, b, c, d, e, f);
        return {f, e, d, c, b, a};
    endfunction

    task automatic send_bit(input logic b);
        rand_bit = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send_piece(input logic [2:0] p);
        send_bit(p[2]);
        send_bit(p[1]);
        send_bit(p[0]);
    endtask

    task automatic do_reset();
        rst_l = 1'b0;
        pop_if.piece_req = 1'b0;
        new_game = 1'b0;
        rand_bit = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_l = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (pop_if.piece_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %0d want 0", pop_if.piece_valid); end
        n_cmp++; if (pop_if.piece_out !== 3'd7) begin n_bad++; $display("FAIL rst_out got %0d want 7", pop_if.piece_out); end
        n_cmp++; if (preview !== prev6(3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7)) begin n_bad++; $display("FAIL rst_preview got %h want 3ffff", preview); end
        n_cmp++; if (preview_count !== 4'd0) begin n_bad++; $display("FAIL rst_count got %0d want 0", preview_count); end
        n_cmp++; if (bag_remaining !== 7'h7F) begin n_bad++; $display("FAIL rst_mask got %h want 7f", bag_remaining); end
        n_cmp++; if (reject_count !== 16'h0) begin n_bad++; $display("FAIL rst_rej got %0d want 0", reject_count); end
    endtask

    task automatic test_first_piece();
        do_reset();
        send_bit(1'b0);
        send_bit(1'b1);
        n_cmp++; if (pop_if.piece_valid !== 1'b0) begin n_bad++; $display("FAIL first_early_valid got %0d want 0", pop_if.piece_valid); end
        send_bit(1'b0);
        n_cmp++; if (pop_if.piece_valid !== 1'b1) begin n_bad++; $display("FAIL first_valid got %0d want 1", pop_if.piece_valid); end
        n_cmp++; if (pop_if.piece_out !== 3'd2) begin n_bad++; $display("FAIL first_out got %0d want 2", pop_if.piece_out); end
        n_cmp++; if (bag_remaining !== 7'h7B) begin n_bad++; $display("FAIL first_mask got %h want 7b", bag_remaining); end
        n_cmp++; if (preview_count !== 4'd1) begin n_bad++; $display("FAIL first_count got %0d want 1", preview_count); end
        n_cmp++; if (preview !== prev6(3'd2, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7)) begin n_bad++; $display("FAIL first_preview got %h want 3fffa", preview); end
    endtask

    task automatic test_reject();
        logic [15:0] exp_rej;
`ifdef PIECE_BAG_STATS_EN
        exp_rej = 16'd2;
`else
        exp_rej = 16'd0;
`endif
        do_reset();
        send_piece(3'd7);
        send_piece(3'd2);
        send_piece(3'd2);
        n_cmp++; if (preview_count !== 4'd1) begin n_bad++; $display("FAIL rej_count got %0d want 1", preview_count); end
        n_cmp++; if (pop_if.piece_out !== 3'd2) begin n_bad++; $display("FAIL rej_out got %0d want 2", pop_if.piece_out); end
        n_cmp++; if (bag_remaining !== 7'h7B) begin n_bad++; $display("FAIL rej_mask got %h want 7b", bag_remaining); end
        n_cmp++; if (reject_count !== exp_rej) begin n_bad++; $display("FAIL rej_stat got %0d want %0d", reject_count, exp_rej); end
    endtask

    task automatic test_full_and_pop_push();
        do_reset();
        for (int p = 0; p < 7; p++) send_piece(3'(p));
        n_cmp++; if (preview_count !== 4'd6) begin n_bad++; $display("FAIL full_count got %0d want 6", preview_count); end
        n_cmp++; if (preview !== prev6(3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5)) begin n_bad++; $display("FAIL full_preview got %h want %h", preview, prev6(3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5)); end
        n_cmp++; if (bag_remaining !== 7'h40) begin n_bad++; $display("FAIL full_mask got %h want 40", bag_remaining); end
        send_bit(1'b1);
        send_bit(1'b1);
        pop_if.piece_req = 1'b1;
        send_bit(1'b0);
        pop_if.piece_req = 1'b0;
        n_cmp++; if (preview_count !== 4'd6) begin n_bad++; $display("FAIL pp_count got %0d want 6", preview_count); end
        n_cmp++; if (pop_if.piece_out !== 3'd1) begin n_bad++; $display("FAIL pp_head got %0d want 1", pop_if.piece_out); end
        n_cmp++; if (preview !== prev6(3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6)) begin n_bad++; $display("FAIL pp_preview got %h want %h", preview, prev6(3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6)); end
        n_cmp++; if (bag_remaining !== 7'h7F) begin n_bad++; $display("FAIL pp_mask got %h want 7f", bag_remaining); end
    endtask

    task automatic test_empty_req();
        do_reset();
        pop_if.piece_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send_bit(1'b1);
            n_cmp++; if (pop_if.piece_valid !== 1'b0 || preview_count !== 4'd0) begin n_bad++; $display("FAIL empty_req_%0d got valid %0d count %0d want 0 0", i, pop_if.piece_valid, preview_count); end
        end
        pop_if.piece_req = 1'b0;
        n_cmp++; if ($isunknown({pop_if.piece_out, preview, bag_remaining, reject_count})) begin n_bad++; $display("FAIL empty_req_x got unknown outputs want known"); end
        n_cmp++; if (pop_if.piece_out !== 3'd7) begin n_bad++; $display("FAIL empty_req_out got %0d want 7", pop_if.piece_out); end
    endtask

    task automatic test_new_game();
        do_reset();
        for (int p = 0; p < 4; p++) send_piece(3'(p));
        pop_if.piece_req = 1'b1;
        send_bit(1'b0);
        pop_if.piece_req = 1'b0;
        n_cmp++; if (preview_count !== 4'd3) begin n_bad++; $display("FAIL ng_pre_count got %0d want 3", preview_count); end
        n_cmp++; if (bag_remaining !== 7'h70) begin n_bad++; $display("FAIL ng_pre_mask got %h want 70", bag_remaining); end
        n_cmp++; if (pop_if.piece_out !== 3'd1) begin n_bad++; $display("FAIL ng_pre_head got %0d want 1", pop_if.piece_out); end
        new_game = 1'b1;
        pop_if.piece_req = 1'b1;
        send_bit(1'b1);
        new_game = 1'b0;
        pop_if.piece_req = 1'b0;
        n_cmp++; if (preview_count !== 4'd0) begin n_bad++; $display("FAIL ng_count got %0d want 0", preview_count); end
        n_cmp++; if (bag_remaining !== 7'h7F) begin n_bad++; $display("FAIL ng_mask got %h want 7f", bag_remaining); end
        n_cmp++; if (preview !== prev6(3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7)) begin n_bad++; $display("FAIL ng_preview got %h want 3ffff", preview); end
        send_bit(1'b1);
        send_bit(1'b0);
        n_cmp++; if (preview_count !== 4'd0) begin n_bad++; $display("FAIL ng_early_count got %0d want 0", preview_count); end
        send_bit(1'b0);
        n_cmp++; if (preview_count !== 4'd1) begin n_bad++; $display("FAIL ng_z_count got %0d want 1", preview_count); end
        n_cmp++; if (pop_if.piece_out !== 3'd4) begin n_bad++; $display("FAIL ng_z_out got %0d want 4", pop_if.piece_out); end
        n_cmp++; if (bag_remaining !== 7'h6F) begin n_bad++; $display("FAIL ng_z_mask got %h want 6f", bag_remaining); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send_piece(3'd2);
        send_piece(3'd3);
        n_cmp++; if (preview_count !== 4'd2) begin n_bad++; $display("FAIL mid_pre_count got %0d want 2", preview_count); end
        send_bit(1'b1);
        rst_l = 1'b0;
        #2;
        n_cmp++; if (pop_if.piece_valid !== 1'b0 || preview_count !== 4'd0) begin n_bad++; $display("FAIL mid_rst_q got valid %0d count %0d want 0 0", pop_if.piece_valid, preview_count); end
        n_cmp++; if (pop_if.piece_out !== 3'd7 || preview !== prev6(3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7)) begin n_bad++; $display("FAIL mid_rst_out got %0d %h want 7 3ffff", pop_if.piece_out, preview); end
        n_cmp++; if (bag_remaining !== 7'h7F) begin n_bad++; $display("FAIL mid_rst_mask got %h want 7f", bag_remaining); end
        #2;
        rst_l = 1'b1;
        send_bit(1'b1);
        send_bit(1'b0);
        n_cmp++; if (preview_count !== 4'd0) begin n_bad++; $display("FAIL mid_early_count got %0d want 0", preview_count); end
        send_bit(1'b1);
        n_cmp++; if (preview_count !== 4'd1 || pop_if.piece_out !== 3'd5) begin n_bad++; $display("FAIL mid_j got count %0d out %0d want 1 5", preview_count, pop_if.piece_out); end
    endtask

    initial begin
        pop_if.piece_req = 1'b0;
        test_reset();
        test_first_piece();
        test_reject();
        test_full_and_pop_push();
        test_empty_req();
        test_new_game();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
